// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Sole driver of the register-file write port. Merges single-cycle ALU
//   results with variable-latency LSU results. LSU results wait in an
//   in-order FIFO whose entries can be killed by a younger ALU write to the
//   same destination, so a stale load never overwrites a newer ALU value.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data ALU result (always accepted, highest priority)
//   lsu_valid/lsu_rd/lsu_data LSU result offer; lsu_ready = FIFO not full
//   writeReg/writeData/rd_we  registered register-file write port
//   pending                   bit r set while a live queued entry targets xr
//   occupancy                 FIFO entries held, live and dead
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [31:0]              lsu_data,
    output logic [4:0]               writeReg,
    output logic [31:0]              writeData,
    output logic                     rd_we,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    typedef struct packed {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t          fifo [DEPTH];
    logic [PW-1:0]   rdPtr, wrPtr;
    logic [OW-1:0]   count;
    logic [31:0]     pendingVec;

    logic  aluWrite, push, pop;
    entry_t head;

    assign lsu_ready = (count != FULL);
    assign occupancy = count;
    assign head      = fifo[rdPtr];

    assign aluWrite  = alu_valid && (alu_rd != 5'd0);
    // x0 results complete the handshake but are never stored.
    assign push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    // Any ALU traffic, even to x0, keeps the port and blocks the pop.
    assign pop       = !alu_valid && (count != '0);

    always_comb begin
        pendingVec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo[i].live) pendingVec[fifo[i].rd] = 1'b1;
        end
        pendingVec[0] = 1'b0;
    end
    assign pending = pendingVec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
            rd_we     <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            // Kill older queued writes to the ALU's destination. The push
            // below is applied after this loop, so an entry arriving at the
            // same edge overrides the kill and stays live.
            if (aluWrite) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (fifo[i].live && fifo[i].rd == alu_rd)
                        fifo[i].live <= 1'b0;
                end
            end

            // A popped slot is cleared so it drops out of pending. Push and
            // pop never hit the same slot: pop needs count>0, push needs
            // count<DEPTH, so the pointers differ whenever both fire.
            if (pop) begin
                fifo[rdPtr].live <= 1'b0;
                rdPtr            <= rdPtr + 1'b1;
            end
            if (push) begin
                fifo[wrPtr] <= '{live: 1'b1, rd: lsu_rd, data: lsu_data};
                wrPtr       <= wrPtr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (aluWrite) begin
                rd_we     <= 1'b1;
                writeReg  <= alu_rd;
                writeData <= alu_data;
            end else if (pop && head.live) begin
                rd_we     <= 1'b1;
                writeReg  <= head.rd;
                writeData <= head.data;
            end else begin
                rd_we     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_data = '0;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        rd_we;
    logic [31:0] pending;
    logic [$clog2(DEPTH):0] occupancy;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .writeReg(writeReg), .writeData(writeData), .rd_we(rd_we),
        .pending(pending), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of queued LSU results plus the
    // expected write-port registers and an architectural register file.
    typedef struct {
        bit       live;
        bit [4:0] rd;
        bit [31:0] data;
    } ment_t;

    ment_t     q[$];
    bit        expWe;
    bit [4:0]  expReg;
    bit [31:0] expData;
    bit [31:0] modelRf [32];
    logic [31:0] dutRf [32];

    int checks = 0;
    int errors = 0;

    always @(posedge clk) if (rd_we === 1'b1) dutRf[writeReg] <= writeData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] expPending();
        bit [31:0] p = '0;
        foreach (q[i]) if (q[i].live) p[q[i].rd] = 1'b1;
        return p;
    endfunction

    task automatic checkAll(input string tag);
        chk({tag, ".rd_we"},     32'(rd_we),     32'(expWe));
        chk({tag, ".writeReg"},  32'(writeReg),  32'(expReg));
        chk({tag, ".writeData"}, writeData,      expData);
        chk({tag, ".occupancy"}, 32'(occupancy), q.size());
        chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(q.size() < DEPTH));
        chk({tag, ".pending"},   pending,        expPending());
    endtask

    task automatic modelReset();
        q.delete();
        expWe = 0; expReg = '0; expData = '0;
    endtask

    // One clock: drive inputs, advance the model by the rules, check after edge.
    task automatic step(input string tag,
                        input bit av, input bit [4:0] ar, input bit [31:0] ad,
                        input bit lv, input bit [4:0] lr, input bit [31:0] ld);
        bit ready;
        ment_t h;
        @(negedge clk);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
        ready = (q.size() < DEPTH);
        if (av && ar != 0) begin
            foreach (q[i]) if (q[i].rd == ar) q[i].live = 0;
            expWe = 1; expReg = ar; expData = ad;
        end else if (av) begin
            expWe = 0;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            expWe = h.live;
            if (h.live) begin expReg = h.rd; expData = h.data; end
        end else begin
            expWe = 0;
        end
        if (lv && ready && lr != 0) q.push_back('{live: 1, rd: lr, data: ld});
        if (expWe) modelRf[expReg] = expData;
        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        foreach (modelRf[i]) begin modelRf[i] = '0; dutRf[i] = '0; end
        modelReset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst = 0;
        idle("post_reset");

        // ALU path
        step("alu5", 1, 5, 32'hA5A5A5A5, 0, 0, 0);
        chk("alu5.we", 32'(rd_we), 1);
        chk("alu5.data", writeData, 32'hA5A5A5A5);
        idle("alu5_after");
        chk("alu5.one_cycle", 32'(rd_we), 0);
        step("alu0", 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        chk("alu0.no_we", 32'(rd_we), 0);

        // LSU path
        step("lsu10", 0, 0, 0, 1, 10, 32'h12345678);
        chk("lsu10.pending", 32'(pending[10]), 1);
        idle("lsu10_pop");
        chk("lsu10.write", writeData, 32'h12345678);
        chk("lsu10.pending_clr", 32'(pending[10]), 0);

        // Fill and backpressure with ALU holding the port (x0 writes)
        for (int i = 1; i <= 5; i++)
            step("fill", 1, 0, 0, 1, 5'(i), 32'h1000_0000 + i);
        chk("fill.ready_low", 32'(lsu_ready), 0);
        chk("fill.occ", 32'(occupancy), DEPTH);
        for (int i = 1; i <= 4; i++) begin
            idle("drain");
            chk("drain.order", 32'(writeReg), i);
            chk("drain.ready", 32'(lsu_ready), 1);
        end

        // Kill
        step("kill_q", 1, 0, 0, 1, 7, 32'h11111111);
        step("kill_alu", 1, 7, 32'h22222222, 0, 0, 0);
        chk("kill.pending7", 32'(pending[7]), 0);
        idle("kill_pop");
        chk("kill.dead_pop", 32'(rd_we), 0);
        idle("kill_settle");
        chk("kill.x7", dutRf[7], 32'h22222222);

        // Simultaneous ALU write, kill and same-rd push
        step("sim_q", 1, 0, 0, 1, 3, 32'hAAAA0003);
        step("sim_edge", 1, 3, 32'h03030303, 1, 3, 32'h33333333);
        chk("sim.pending3", 32'(pending[3]), 1);
        idle("sim_pop_dead");
        idle("sim_pop_live");
        chk("sim.live_write", writeData, 32'h33333333);
        idle("sim_settle");
        chk("sim.x3", dutRf[3], 32'h33333333);

        // Mid-stream reset with three entries queued
        for (int i = 0; i < 3; i++)
            step("rst_q", 1, 0, 0, 1, 5'(20 + i), 32'hBEEF0000 + i);
        @(negedge clk);
        alu_valid = 0; lsu_valid = 0;
        #2 rst = 1;
        #1;
        modelReset();
        checkAll("midreset");
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            idle("post_midreset");
            chk("post_midreset.no_we", 32'(rd_we), 0);
        end

        // Randomized traffic, small rd range to provoke kills
        for (int n = 0; n < 1500; n++) begin
            step("rand",
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
        end
        repeat (DEPTH + 2) idle("rand_drain");
        for (int r = 1; r < 8; r++) chk("rand.rf", dutRf[r], modelRf[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
